// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding and the
// counter saturation value.
package period_meter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure
    } state_e;

    // All-ones value for a counter of the given width (widths up to 32 bits).
    function automatic logic [31:0] cnt_max(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// Result/handshake bundle of the period meter. The meter drives the master
// side; the consumer of measurements holds the slave side.
interface period_meter_if #(
    parameter int unsigned CNT_W = 24
);
    logic             valid;
    logic             ack;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             overrun;
    logic             timeout;

    modport master (
        output valid, period, high_time, overrun, timeout,
        input  ack
    );

    modport slave (
        input  valid, period, high_time, overrun, timeout,
        output ack
    );
endinterface

// File: rtl/period_meter_sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous input followed by registered
// one-cycle edge pulses. Fall detection exists only with PERIOD_METER_HIGH_TIME_EN.
module period_meter_sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
`ifdef PERIOD_METER_HIGH_TIME_EN
    output logic fall_o,
`endif
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

`ifdef PERIOD_METER_HIGH_TIME_EN
    logic fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign fall_o = fall_q;
`endif

endmodule

// File: rtl/period_meter.sv
// Measures rise-to-rise period of a slow asynchronous input in clk cycles and
// hands results out over valid/ack. Define PERIOD_METER_HIGH_TIME_EN for high_time.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in_i,
    input  logic          en_i,
    period_meter_if.master res_if
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

    logic             rise;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q;
    logic             valid_q, overrun_q, timeout_q;
    logic             cap, cap_to;

`ifdef PERIOD_METER_HIGH_TIME_EN
    logic fall;
`endif

    period_meter_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in_i),
`ifdef PERIOD_METER_HIGH_TIME_EN
        .fall_o (fall),
`endif
        .rise_o (rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        cap_to  = 1'b0;
        if (!en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArm;
                StArm: begin
                    if (rise) begin
                        state_d = StMeasure;
                        cnt_d   = CNT_W'(1);
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        cap   = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CntMax) begin
                        // No rise within the counter range: report a saturated result.
                        cap     = 1'b1;
                        cap_to  = 1'b1;
                        state_d = StArm;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!en_i) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end else if (cap) begin
                period_q  <= cap_to ? CntMax : cnt_q;
                timeout_q <= cap_to;
                if (valid_q && !res_if.ack) begin
                    overrun_q <= 1'b1;
                end
            end
            // A capture always wins over a same-cycle ack.
            if (cap) begin
                valid_q <= 1'b1;
            end else if (res_if.ack) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef PERIOD_METER_HIGH_TIME_EN
    logic [CNT_W-1:0] fall_cnt_q;
    logic [CNT_W-1:0] high_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fall_cnt_q <= '0;
            high_q     <= '0;
        end else begin
            if (en_i && (state_q == StMeasure) && fall) begin
                fall_cnt_q <= cnt_q;
            end
            if (cap) begin
                high_q <= cap_to ? CntMax : fall_cnt_q;
            end
        end
    end

    assign res_if.high_time = high_q;
`else
    assign res_if.high_time = '0;
`endif

    assign res_if.period  = period_q;
    assign res_if.valid   = valid_q;
    assign res_if.overrun = overrun_q;
    assign res_if.timeout = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus random square
// waves, compared against a time-difference model of rise events.
module tb_period_meter;

    localparam int unsigned CW   = 8;
    localparam int unsigned SS   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic sig;
    logic en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_period, m_high, m_rises, m_last_rise, m_last_h;
    bit m_valid, m_overrun, m_timeout;

    period_meter_if #(.CNT_W(CW)) res_if ();

    period_meter #(
        .CNT_W       (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in_i (sig),
        .en_i     (en),
        .res_if   (res_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_high();
`ifdef PERIOD_METER_HIGH_TIME_EN
        return m_high;
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "/period"}, 32'(res_if.period), m_period);
        chk({tag, "/high_time"}, 32'(res_if.high_time), exp_high());
        chk({tag, "/valid"}, 32'(res_if.valid), 32'(m_valid));
        chk({tag, "/overrun"}, 32'(res_if.overrun), 32'(m_overrun));
        chk({tag, "/timeout"}, 32'(res_if.timeout), 32'(m_timeout));
    endtask

    task automatic model_reset();
        m_period  = 0;
        m_high    = 0;
        m_rises   = 0;
        m_valid   = 0;
        m_overrun = 0;
        m_timeout = 0;
    endtask

    task automatic model_capture(input int p, input int hi, input bit to);
        if (m_valid) m_overrun = 1;
        m_valid   = 1;
        m_period  = p;
        m_high    = hi;
        m_timeout = to;
    endtask

    // A result needs two rises since the last (re)arm; its value is their spacing.
    task automatic model_rise(input int h);
        if (m_rises > 0) model_capture(cyc - m_last_rise, m_last_h, 0);
        m_rises++;
        m_last_rise = cyc;
        m_last_h    = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // One high/low cycle of sig; checks near the end of the low phase, optional ack.
    task automatic pulse(input int h, input int l, input bit do_ack);
        for (int c = 0; c < h + l; c++) begin
            tick();
            sig = (c < h);
            if (c == 0) model_rise(h);
            if (c == h + l - 2) begin
                sample();
                check_all("pulse");
                if (do_ack) res_if.ack = 1'b1;
            end
            if (c == h + l - 1 && do_ack) begin
                res_if.ack = 1'b0;
                m_valid    = 0;
                sample();
                chk("ack_drop", 32'(res_if.valid), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, l;
        rst        = 1'b1;
        sig        = 1'b0;
        en         = 1'b0;
        res_if.ack = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        en = 1'b1;
        tick();
        tick();

        // 10-cycle square wave, then ack, then overrun with a 12-cycle wave.
        pulse(5, 5, 0);
        pulse(5, 5, 1);
        pulse(6, 6, 0);
        pulse(6, 6, 0);
        pulse(6, 6, 1);

        repeat (12) begin
            h = int'($urandom_range(4, 12));
            l = int'($urandom_range(4, 12));
            pulse(h, l, 1'($urandom_range(0, 1)));
        end

        // Single rise then sig held low until the counter saturates.
        for (int c = 0; c <= 262; c++) begin
            tick();
            sig = (c < 4);
            if (c == 0) model_rise(4);
            if (c == 10) begin
                sample();
                check_all("to_pre");
                res_if.ack = 1'b1;
            end
            if (c == 11) begin
                res_if.ack = 1'b0;
                m_valid    = 0;
            end
            if (c == 258) begin
                sample();
                check_all("to_edge");
            end
            if (c == 259) begin
                m_rises = 0;
                model_capture(CMAX, CMAX, 1);
                sample();
                check_all("timeout");
            end
        end
        pulse(5, 5, 1);
        pulse(5, 5, 1);

        // Asynchronous reset in the middle of a period-20 measurement.
        pulse(10, 10, 1);
        pulse(10, 10, 1);
        for (int c = 0; c < 20; c++) begin
            tick();
            sig = (c < 10);
            if (c == 0) model_rise(10);
            if (c == 15) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rst_async");
            end
            if (c == 17) rst = 1'b0;
        end
        pulse(10, 10, 1);
        pulse(10, 10, 1);

        // One-cycle enable drop while overrun is set.
        pulse(8, 8, 0);
        pulse(8, 8, 0);
        for (int c = 0; c < 16; c++) begin
            tick();
            sig = (c < 8);
            if (c == 0) model_rise(8);
            if (c == 12) en = 1'b0;
            if (c == 13) begin
                en        = 1'b1;
                m_overrun = 0;
                m_timeout = 0;
                m_rises   = 0;
                sample();
                check_all("en_drop");
            end
        end
        pulse(7, 7, 1);
        pulse(7, 7, 1);
        pulse(7, 7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
